// File: rtl/adaptive_step_controller_pkg.sv
// Shared types and default step limits for the adaptive step controller.
package ode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACCUM,
        DECIDE,
        DONE
    } state_t;

    localparam logic [15:0] STEP_MIN_DEFAULT = 16'h0004;
    localparam logic [15:0] STEP_MAX_DEFAULT = 16'h4000;

endpackage

// File: rtl/adaptive_step_controller_if.sv
// Sequencer and state-RAM signals of the adaptive step controller in one bundle.
interface adaptive_step_controller_if #(
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     init;
    logic                     start;
    logic                     read_step;
    logic [WORD_SIZE-1:0]     step_in;
    logic [WORD_SIZE-1:0]     tol_in;
    logic [ADDRESS_WIDTH-1:0] x0_address;
    logic [ADDRESS_WIDTH-1:0] x1_address;
    logic                     done;
    logic                     proceed;
    logic                     error;
    logic [ADDRESS_WIDTH-1:0] memory_address1;
    logic [ADDRESS_WIDTH-1:0] memory_address2;
    logic [WORD_SIZE-1:0]     memory_data1;
    logic [WORD_SIZE-1:0]     memory_data2;
    logic [WORD_SIZE-1:0]     step_out;

    // The master side is the sequencer together with the state RAM.
    modport master (
        output init, start, read_step, step_in, tol_in, x0_address, x1_address,
        output memory_data1, memory_data2,
        input  done, proceed, error, memory_address1, memory_address2, step_out
    );

    modport slave (
        input  init, start, read_step, step_in, tol_in, x0_address, x1_address,
        input  memory_data1, memory_data2,
        output done, proceed, error, memory_address1, memory_address2, step_out
    );
endinterface

// File: rtl/adaptive_step_controller_abs_diff_max.sv
// Streaming accumulator of max |x1 - x0|; the difference is kept one bit wider
// than the operands so the magnitude never wraps.
module abs_diff_max #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic [WORD_SIZE-1:0] i_x0,
    input  logic [WORD_SIZE-1:0] i_x1,
    output logic [WORD_SIZE:0]   o_max
);
    logic [WORD_SIZE:0] w_diff;
    logic [WORD_SIZE:0] w_abs;
    logic [WORD_SIZE:0] r_max;

    assign w_diff = {i_x1[WORD_SIZE-1], i_x1} - {i_x0[WORD_SIZE-1], i_x0};

    // NOTE: w_abs gets a default before the conditional so no latch is inferred.
    always_comb begin
        w_abs = w_diff;
        if (w_diff[WORD_SIZE]) w_abs = '0 - w_diff;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_max <= '0;
        else if (i_clear)                  r_max <= '0;
        else if (i_en && (w_abs > r_max))  r_max <= w_abs;
    end

    assign o_max = r_max;
endmodule

// File: rtl/adaptive_step_controller.sv
// Local-error step controller: streams N_VARS state pairs from the RAM, takes the
// max-abs difference and halves, keeps or doubles the step.
module adaptive_step_controller
    import ode_pkg::*;
#(
    parameter int                   WORD_SIZE     = 16,
    parameter int                   ADDRESS_WIDTH = 4,
    parameter int                   N_VARS        = 4,
    parameter logic [WORD_SIZE-1:0] STEP_MIN      = WORD_SIZE'(STEP_MIN_DEFAULT),
    parameter logic [WORD_SIZE-1:0] STEP_MAX      = WORD_SIZE'(STEP_MAX_DEFAULT)
) (
    input logic                       clk,
    input logic                       rst,
    adaptive_step_controller_if.slave bus
);
    localparam int CW = $clog2(N_VARS + 2);

    state_t                   r_state;
    logic [CW-1:0]            r_idx;
    logic [ADDRESS_WIDTH-1:0] r_addr1;
    logic [ADDRESS_WIDTH-1:0] r_addr2;
    logic [WORD_SIZE-1:0]     r_step;
    logic [WORD_SIZE-1:0]     r_tol;
    logic                     r_done;
    logic                     r_proceed;
    logic                     r_error;

    logic                     w_start_go;
    logic                     w_acc_en;
    logic [WORD_SIZE:0]       w_max;
    logic [WORD_SIZE:0]       w_tol_ext;
    logic [WORD_SIZE:0]       w_step_dbl;
    logic [WORD_SIZE-1:0]     w_step_half;

    assign w_start_go  = (r_state == IDLE) && bus.start && !bus.init;
    // r_idx counts cycles since start; data for index r_idx-1 is on the RAM bus.
    assign w_acc_en    = ((r_state == ISSUE) || (r_state == ACCUM)) && (r_idx != '0);
    assign w_tol_ext   = {1'b0, r_tol};
    assign w_step_dbl  = {r_step, 1'b0};
    assign w_step_half = r_step >> 1;

    abs_diff_max #(
        .WORD_SIZE(WORD_SIZE)
    ) u_abs_diff_max (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_start_go),
        .i_en   (w_acc_en),
        .i_x0   (bus.memory_data1),
        .i_x1   (bus.memory_data2),
        .o_max  (w_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_addr1   <= '0;
            r_addr2   <= '0;
            r_step    <= '0;
            r_tol     <= '0;
            r_done    <= 1'b0;
            r_proceed <= 1'b0;
            r_error   <= 1'b0;
        end else if (bus.init) begin
            r_state   <= IDLE;
            r_step    <= bus.step_in;
            r_done    <= 1'b0;
            r_proceed <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state   <= (N_VARS == 1) ? ACCUM : ISSUE;
                        r_idx     <= '0;
                        r_addr1   <= bus.x0_address;
                        r_addr2   <= bus.x1_address;
                        r_tol     <= bus.tol_in;
                        r_proceed <= 1'b0;
                        r_error   <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_idx   <= r_idx + 1'b1;
                    r_addr1 <= r_addr1 + 1'b1;
                    r_addr2 <= r_addr2 + 1'b1;
                    if (r_idx == CW'(N_VARS - 2)) r_state <= ACCUM;
                end
                ACCUM: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == CW'(N_VARS)) r_state <= DECIDE;
                end
                DECIDE: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    if (w_max > w_tol_ext) begin
                        r_proceed <= 1'b0;
                        if (w_step_half < STEP_MIN) begin
                            r_error <= 1'b1;
                        end else begin
                            r_error <= 1'b0;
                            r_step  <= w_step_half;
                        end
                    end else begin
                        r_proceed <= 1'b1;
                        r_error   <= 1'b0;
                        // Doubling is evaluated one bit wide so saturation sees the true value.
                        if (w_max < (w_tol_ext >> 2)) begin
                            r_step <= (w_step_dbl > {1'b0, STEP_MAX}) ? STEP_MAX
                                                                      : w_step_dbl[WORD_SIZE-1:0];
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.done            = r_done;
    assign bus.proceed         = r_proceed;
    assign bus.error           = r_error;
    assign bus.memory_address1 = r_addr1;
    assign bus.memory_address2 = r_addr2;
    assign bus.step_out        = bus.read_step ? r_step : '0;
endmodule
